// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the datapath-to-bus request bridge.
// Holds the FSM state encoding and the strobe-to-size mapping.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Returns {size, addr_lo}; odd strobe patterns fall back to a word.
  function automatic logic [3:0] sel_to_size_off(input logic [3:0] sel);
    logic [3:0] r;
    case (sel)
      4'b0001: r = {SIZE_BYTE, 2'd0};
      4'b0010: r = {SIZE_BYTE, 2'd1};
      4'b0100: r = {SIZE_BYTE, 2'd2};
      4'b1000: r = {SIZE_BYTE, 2'd3};
      4'b0011: r = {SIZE_HALF, 2'd0};
      4'b1100: r = {SIZE_HALF, 2'd2};
      default: r = {SIZE_WORD, 2'd0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_req_bridge.sv
// Bridges a single-cycle SRAM-style data port onto a split-transaction
// bus, stalling the pipeline until each access completes.
module mem_req_bridge
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [3:0]        cpu_sel_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              bus_req_o,
  output logic              bus_wr_o,
  output logic [1:0]        bus_size_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_wstrb_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_addr_ok_i,
  input  logic              bus_data_ok_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [3:0] st_so;
  logic       unused_addr_lo;

  assign st_so          = sel_to_size_off(cpu_sel_i);
  // Low address bits come from the strobes, never from the datapath.
  assign unused_addr_lo = ^cpu_addr_i[1:0];

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_ce_i) begin
          state_d = REQ;
          req_d   = 1'b1;
          wr_d    = cpu_we_i;
          wdata_d = cpu_wdata_i;
          if (cpu_we_i) begin
            size_d  = st_so[3:2];
            addr_d  = {cpu_addr_i[ADDR_W-1:2], st_so[1:0]};
            wstrb_d = cpu_sel_i;
          end else begin
            size_d  = SIZE_WORD;
            addr_d  = {cpu_addr_i[ADDR_W-1:2], 2'b00};
            wstrb_d = 4'b0000;
          end
        end
      end
      REQ: begin
        if (bus_addr_ok_i) begin
          req_d = 1'b0;
          if (bus_data_ok_i) begin
            state_d = DONE;
            if (!wr_q) rdata_d = bus_rdata_i;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_data_ok_i) begin
          state_d = DONE;
          if (!wr_q) rdata_d = bus_rdata_i;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wstrb_q <= 4'd0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign cpu_stall_o = cpu_ce_i && (state_q != DONE);
  assign cpu_rdata_o = rdata_q;
  assign bus_req_o   = req_q;
  assign bus_wr_o    = wr_q;
  assign bus_size_o  = size_q;
  assign bus_addr_o  = addr_q;
  assign bus_wstrb_o = wstrb_q;
  assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_req_bridge.sv
// Directed vector bench for mem_req_bridge with a scripted bus slave.
module tb_mem_req_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we;
  logic [3:0]  sel;
  logic [31:0] addr, wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        breq, bwr;
  logic [1:0]  bsize;
  logic [31:0] baddr;
  logic [3:0]  bstrb;
  logic [31:0] bwdata;
  logic        addr_ok, data_ok;
  logic [31:0] brdata;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;

  always #5 clk = ~clk;

  mem_req_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cpu_ce_i      (ce),
    .cpu_we_i      (we),
    .cpu_sel_i     (sel),
    .cpu_addr_i    (addr),
    .cpu_wdata_i   (wdata),
    .cpu_rdata_o   (cpu_rdata),
    .cpu_stall_o   (stall),
    .bus_req_o     (breq),
    .bus_wr_o      (bwr),
    .bus_size_o    (bsize),
    .bus_addr_o    (baddr),
    .bus_wstrb_o   (bstrb),
    .bus_wdata_o   (bwdata),
    .bus_addr_ok_i (addr_ok),
    .bus_data_ok_i (data_ok),
    .bus_rdata_i   (brdata)
  );

  always @(posedge clk) begin
    if (!rst && breq && addr_ok) acc_cnt++;
    if (!rst && breq && data_ok && !addr_ok)
      $error("protocol: data_ok without addr_ok");
  end

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brd;
    int          aw;
    int          dw;
    logic [1:0]  size;
    logic [31:0] baddr;
    logic [3:0]  strb;
    logic [31:0] rd;
    int          nstall;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Slave asserts addr_ok aw cycles into REQ, data_ok dw cycles later.
  task automatic run_vec(input vec_t v, input string tag);
    int done_k = 2 + v.aw + v.dw;
    int st_cnt = 0;
    int rq_cnt = 0;
    for (int k = 0; k <= done_k; k++) begin
      @(negedge clk);
      ce      = 1'b1;
      we      = v.we;
      sel     = v.sel;
      addr    = v.addr;
      wdata   = v.wdata;
      brdata  = v.brd;
      addr_ok = (k == 1 + v.aw);
      data_ok = (k == 1 + v.aw + v.dw);
      #1;
      if (k < done_k) st_cnt += int'(stall);
      else chk({tag, " stall_done"}, {31'd0, stall}, 32'd0);
      rq_cnt += int'(breq);
      if (k == 1) begin
        chk({tag, " wr"}, {31'd0, bwr}, {31'd0, v.we});
        chk({tag, " size"}, {30'd0, bsize}, {30'd0, v.size});
        chk({tag, " addr"}, baddr, v.baddr);
        chk({tag, " wstrb"}, {28'd0, bstrb}, {28'd0, v.strb});
        if (v.we) chk({tag, " wdata"}, bwdata, v.wdata);
      end
      if (k == done_k) chk({tag, " rdata"}, cpu_rdata, v.rd);
    end
    chk({tag, " stall_cycles"}, st_cnt, v.nstall);
    chk({tag, " req_cycles"}, rq_cnt, 1 + v.aw);
  endtask

  task automatic idle_cycles(input int n, input logic [31:0] exp_rd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ce      = 1'b0;
      addr_ok = 1'b0;
      data_ok = 1'b0;
      #1;
      chk("idle req", {31'd0, breq}, 32'd0);
      chk("idle stall", {31'd0, stall}, 32'd0);
      chk("idle rdata", cpu_rdata, exp_rd);
    end
  endtask

  initial begin
    vec_t rv;
    vecs[0]  = '{1'b0, 4'h0, 32'h1000, 32'h0,        32'hDEADBEEF,
                 0, 2, 2'd2, 32'h1000, 4'h0, 32'hDEADBEEF, 4};
    vecs[1]  = '{1'b1, 4'h4, 32'h2000, 32'h00AB0000, 32'h12345678,
                 1, 1, 2'd0, 32'h2002, 4'h4, 32'hDEADBEEF, 4};
    vecs[2]  = '{1'b1, 4'hC, 32'h3000, 32'hAABB0000, 32'h0,
                 0, 0, 2'd1, 32'h3002, 4'hC, 32'hDEADBEEF, 2};
    vecs[3]  = '{1'b0, 4'hF, 32'h4003, 32'h0,        32'hCAFEF00D,
                 2, 0, 2'd2, 32'h4000, 4'h0, 32'hCAFEF00D, 4};
    vecs[4]  = '{1'b1, 4'h1, 32'h5000, 32'h00000011, 32'h0,
                 0, 1, 2'd0, 32'h5000, 4'h1, 32'hCAFEF00D, 3};
    vecs[5]  = '{1'b1, 4'h8, 32'h5000, 32'h22000000, 32'h0,
                 0, 0, 2'd0, 32'h5003, 4'h8, 32'hCAFEF00D, 2};
    vecs[6]  = '{1'b1, 4'h3, 32'h5000, 32'h00003344, 32'h0,
                 0, 0, 2'd1, 32'h5000, 4'h3, 32'hCAFEF00D, 2};
    vecs[7]  = '{1'b1, 4'hF, 32'h5000, 32'h55667788, 32'h0,
                 0, 0, 2'd2, 32'h5000, 4'hF, 32'hCAFEF00D, 2};
    vecs[8]  = '{1'b1, 4'h5, 32'h5000, 32'h00AA00BB, 32'h0,
                 0, 0, 2'd2, 32'h5000, 4'h5, 32'hCAFEF00D, 2};
    vecs[9]  = '{1'b1, 4'h2, 32'h7000, 32'h00009900, 32'h0,
                 0, 0, 2'd0, 32'h7001, 4'h2, 32'hCAFEF00D, 2};
    vecs[10] = '{1'b0, 4'h1, 32'h6001, 32'h0,        32'h0BADF00D,
                 1, 0, 2'd2, 32'h6000, 4'h0, 32'h0BADF00D, 3};

    rst = 1'b1; ce = 1'b0; we = 1'b0; sel = 4'h0;
    addr = 32'h0; wdata = 32'h0;
    addr_ok = 1'b0; data_ok = 1'b0; brdata = 32'h0;
    #2;
    chk("reset req", {31'd0, breq}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset rdata", cpu_rdata, 32'd0);
    chk("reset addr", baddr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ce stays high from one access to the next: back-to-back traffic.
    acc_cnt = 0;
    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));
    idle_cycles(3, 32'h0BADF00D);
    chk("accepted count", acc_cnt, 32'd11);

    // Reset while a store sits in WAIT.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ce = 1'b1; we = 1'b1; sel = 4'hF;
      addr = 32'h9000; wdata = 32'hFFFFFFFF;
      addr_ok = (k == 1); data_ok = 1'b0;
    end
    #1;
    chk("pre-rst wr", {31'd0, bwr}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1; ce = 1'b0; addr_ok = 1'b0;
    #1;
    chk("rst req", {31'd0, breq}, 32'd0);
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst rdata", cpu_rdata, 32'd0);
    chk("rst wr", {31'd0, bwr}, 32'd0);
    chk("rst addr", baddr, 32'd0);
    chk("rst wdata", bwdata, 32'd0);
    chk("rst wstrb", {28'd0, bstrb}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rv = '{1'b0, 4'h0, 32'h8004, 32'h0, 32'h13579BDF,
           0, 1, 2'd2, 32'h8004, 4'h0, 32'h13579BDF, 3};
    run_vec(rv, "post-rst");
    idle_cycles(2, 32'h13579BDF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_req_bridge.md
Name: mem_req_bridge

Overview:
- Sits between the datapath's single-cycle SRAM-style data port and a split-transaction memory bus (req/addr_ok/data_ok), in place of a fixed-latency data RAM.
- Launches one bus transaction per datapath access and stalls the pipeline until that transaction completes.
- Captures read data and holds it for the datapath.
- Converts byte-select strobes into bus size/address encoding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; DATA_W/8 byte strobes.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- cpu_ce_i  in  1  datapath access request; held steady while cpu_stall_o=1.
- cpu_we_i  in  1  1=store, 0=load.
- cpu_sel_i  in  4  byte strobes for stores; ignored for loads.
- cpu_addr_i  in  ADDR_W  byte address.
- cpu_wdata_i  in  DATA_W  store data, already lane-aligned.
- cpu_rdata_o  out  DATA_W  last completed load word.
- cpu_stall_o  out  1  pipeline freeze.
- bus_req_o  out  1  request valid.
- bus_wr_o  out  1  1=write.
- bus_size_o  out  2  0=byte, 1=half, 2=word.
- bus_addr_o  out  ADDR_W  request address.
- bus_wstrb_o  out  4  write strobes.
- bus_wdata_o  out  DATA_W  write data.
- bus_addr_ok_i  in  1  request accepted.
- bus_data_ok_i  in  1  transaction complete / read data valid.
- bus_rdata_i  in  DATA_W  read data.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE.
  - All bus_* outputs = 0.
  - cpu_rdata_o = 0.
  - cpu_stall_o = 0.
  - Any in-flight bus transaction is abandoned; the bus slave shares rst_i.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If cpu_ce_i=1, register the request fields into bus_* and go to REQ.
  - The registered fields are we, derived size, aligned address, sel, and wdata.
- REQ:
  - bus_req_o=1; fields held stable until the accepting edge.
  - On addr_ok=1 with data_ok=0: go to WAIT, bus_req_o drops.
  - On addr_ok=1 with data_ok=1 in the same cycle: go directly to DONE.
- WAIT:
  - On data_ok=1: if the access is a load, capture bus_rdata_i into cpu_rdata_o; go to DONE.
  - data_ok arriving while in REQ without addr_ok is a protocol violation; ignore it (assertion in bench).
- DONE:
  - Lasts exactly one cycle, then returns to IDLE unconditionally.
  - The pipeline advances during this cycle.
  - A new cpu_ce_i seen in IDLE on the following cycle is a new access.
  - Hence no access is issued twice.
- cpu_stall_o is combinational: cpu_ce_i && (state != DONE).
  - Stall asserts in the same cycle a request appears in IDLE.
  - Minimum stall is 2 cycles (IDLE, REQ) when addr_ok and data_ok coincide.
  - Each extra wait cycle on addr_ok or data_ok adds one stall cycle.
- Load encoding:
  - bus_wr_o=0, bus_size_o=2, bus_wstrb_o=0.
  - bus_addr_o = cpu_addr_i with bits[1:0] cleared.
  - Lane extraction and sign extension stay in the datapath.
- Store encoding, from cpu_sel_i:
  - 0001/0010/0100/1000 give size 0, with address low bits = index of the set bit.
  - 0011/1100 give size 1, with low bits 00 or 10.
  - 1111 gives size 2, with low bits 00.
  - Any other pattern: size 2, low bits 00, strobes passed through unchanged.
  - bus_wdata_o = cpu_wdata_i unchanged.
- cpu_rdata_o holds its value across stores and idle cycles; it changes only on load completion or reset.
- cpu_ce_i dropping mid-transaction (not allowed by the datapath):
  - The transaction still completes.
  - cpu_stall_o follows cpu_ce_i.

Decomposition:
- Package mem_bridge_pkg holds:
  - the state enum {IDLE, REQ, WAIT, DONE};
  - size constants SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2;
  - function sel_to_size_off(sel) returning {size, addr_lo}.
- No sub-module; single-file FSM plus request register.

Test Plan:
1. Load 0x0000_1000, addr_ok after 1 REQ cycle, data_ok 2 cycles later with 0xDEADBEEF:
   - one bus_req pulse window, bus_addr_o=0x1000, size=2;
   - stall high 4 cycles;
   - cpu_rdata_o=0xDEADBEEF in DONE.
2. Store sel=0100, addr 0x2000, wdata 0x00AB0000:
   - bus_wr_o=1, size=0, bus_addr_o=0x2002, wstrb=0100, wdata=0x00AB0000;
   - cpu_rdata_o unchanged.
3. Store sel=1100, addr 0x3000 → size=1, bus_addr_o=0x3002; addr_ok and data_ok in the same cycle → REQ→DONE, stall exactly 2 cycles.
4. Back-to-back load, store, load with ce held continuously → exactly three accepted requests, DONE between each, no duplicate request.
5. rst_i asserted mid-cycle while in WAIT:
   - bus_req_o=0, stall=0, cpu_rdata_o=0 before the next edge;
   - a later request proceeds normally from IDLE.
6. Load at 0x4003 → bus_addr_o=0x4000, wstrb=0, size=2.
